bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 10 +
 rtl/bus_arbiter_rr_pick.sv | 38 +++
 rtl/bus_arbiter.sv | 102 ++++++++++
 tb/tb_bus_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the bus arbiter slice.
package bus_arb_pkg;
  localparam int NUM_REQ_DEF   = 3;
  localparam int MAX_HOLD_DEF  = 4;
  localparam int WORD_SIZE_DEF = 4;
  localparam int IDX_W         = 3;   // owner/index width, covers up to 8 requesters
  localparam int HOLD_W        = 4;   // hold counter width, covers MAX_HOLD up to 15

  typedef enum logic {IDLE, OWNED} arb_state_e;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr_i,
// wrapping to 0, with one optional index masked out.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic [IDX_W-1:0]   excl_i,
  input  logic               excl_en_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] shifted;
  logic [IDX_W:0]     idx;

  // Mask the excluded requester, then scan upward from the pointer.
  always_comb begin
    elig     = req_i & ~(excl_en_i ? (NUM_REQ'(1) << excl_i) : '0);
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    shifted  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
      shifted = elig >> idx;
      if (!any_o && shifted[0]) begin
        any_o    = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with hold-time pre-emption and owner lock.
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           lock,
  input  logic [NUM_REQ*WORD_SIZE-1:0] wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [WORD_SIZE-1:0]         bus,
  output logic                         bus_valid,
  output logic [IDX_W-1:0]             owner,
  output logic                         preempt
);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                preempt_q;

  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic                any_vld;
  logic                own_req, own_lock, hold_hit;
  logic                do_pre, do_grant, go_idle;

  // While owned, the current owner is excluded so it never re-wins a re-arbitration.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .excl_i    (owner_q),
    .excl_en_i (state_q == OWNED),
    .winner_o  (win),
    .any_o     (any_vld)
  );

  // Next-event decode. Pre-emption uses >= so a counter that saturated under
  // lock releases at the first unlocked edge. A release at the same edge wins
  // over pre-emption, so preempt stays low in that case.
  always_comb begin
    own_req  = |(req & gnt_q);
    own_lock = |(lock & gnt_q);
    hold_hit = hold_cnt_q >= HOLD_W'(MAX_HOLD - 1);
    do_pre   = (state_q == OWNED) && own_req && any_vld && !own_lock && hold_hit;
    do_grant = any_vld && ((state_q == IDLE) || !own_req || do_pre);
    go_idle  = (state_q == OWNED) && !own_req && !any_vld;
    rr_ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
  end

  // Arbitration FSM with registered grant, owner and preempt outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      if (do_grant) begin
        state_q    <= OWNED;
        gnt_q      <= NUM_REQ'(1) << win;
        owner_q    <= win;
        rr_ptr_q   <= rr_ptr_d;
        hold_cnt_q <= '0;
        preempt_q  <= do_pre;
      end else if (go_idle) begin
        state_q    <= IDLE;
        gnt_q      <= '0;
        owner_q    <= '0;
        hold_cnt_q <= '0;
      end else if ((state_q == OWNED) && (hold_cnt_q < HOLD_W'(MAX_HOLD))) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  // Bus mux driven from the registered grant; all-zero grant gives a zero bus.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) bus = wdata[i*WORD_SIZE +: WORD_SIZE];
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign preempt   = preempt_q;
  assign bus_valid = (state_q == OWNED);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NUM_REQ=3, WORD_SIZE=4, MAX_HOLD=4).
module tb_bus_arbiter;
  logic        clk;
  logic        reset;
  logic [2:0]  req, lock;
  logic [11:0] wdata;
  logic [2:0]  gnt;
  logic [3:0]  bus;
  logic        bus_valid;
  logic [2:0]  owner;
  logic        preempt;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter #(.NUM_REQ(3), .WORD_SIZE(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .bus(bus), .bus_valid(bus_valid), .owner(owner), .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_g;
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = {4'hC, 4'hA, 4'h5};
    #1;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_bus", {28'd0, bus}, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_owner", {29'd0, owner}, 32'd0);
    chk("rst_preempt", {31'd0, preempt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single requester 1: 1-cycle grant, bus carries its data
    req = 3'b010;
    step();
    chk("r1_gnt", {29'd0, gnt}, 32'b010);
    chk("r1_bus", {28'd0, bus}, 32'hA);
    chk("r1_valid", {31'd0, bus_valid}, 32'd1);
    chk("r1_owner", {29'd0, owner}, 32'd1);
    // Lone owner keeps the bus past MAX_HOLD
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lone_gnt", {29'd0, gnt}, 32'b010);
      chk("lone_pre", {31'd0, preempt}, 32'd0);
    end
    req = 3'b000;
    step();
    chk("idle_gnt", {29'd0, gnt}, 32'd0);
    chk("idle_bus", {28'd0, bus}, 32'd0);
    chk("idle_valid", {31'd0, bus_valid}, 32'd0);

    // All requesting, no lock: rotate 0,1,2,0 every 4 cycles
    do_reset();
    req = 3'b111;
    step();
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      exp_g = 3'b001 << ((c / 4) % 3);
      chk("rot_gnt", {29'd0, gnt}, {29'd0, exp_g});
      chk("rot_pre", {31'd0, preempt}, (c > 0 && c % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Locked owner 0 never pre-empted; unlock releases at the next edge
    do_reset();
    lock = 3'b001;
    req  = 3'b111;
    step();
    chk("lk_gnt0", {29'd0, gnt}, 32'b001);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lk_gnt", {29'd0, gnt}, 32'b001);
      chk("lk_pre", {31'd0, preempt}, 32'd0);
    end
    lock = 3'b000;
    step();
    chk("unlk_gnt", {29'd0, gnt}, 32'b010);
    chk("unlk_pre", {31'd0, preempt}, 32'd1);

    // Owner 2 releases straight to requester 0, pointer wraps to 1
    do_reset();
    req = 3'b100;
    step();
    chk("o2_gnt", {29'd0, gnt}, 32'b100);
    chk("o2_bus", {28'd0, bus}, 32'hC);
    req = 3'b101;
    step();
    chk("o2_hold", {29'd0, gnt}, 32'b100);
    chk("o2_valid", {31'd0, bus_valid}, 32'd1);
    req = 3'b001;
    step();
    chk("hand_gnt", {29'd0, gnt}, 32'b001);
    chk("hand_valid", {31'd0, bus_valid}, 32'd1);
    chk("hand_bus", {28'd0, bus}, 32'h5);
    chk("hand_pre", {31'd0, preempt}, 32'd0);
    req = 3'b000;
    step();
    chk("wrap_idle", {29'd0, gnt}, 32'd0);
    req = 3'b101;
    step();
    chk("wrap_gnt", {29'd0, gnt}, 32'b100);

    // Asynchronous reset mid-cycle while owner 1 holds the bus
    do_reset();
    req = 3'b010;
    step();
    chk("ar_gnt_pre", {29'd0, gnt}, 32'b010);
    #2 reset = 1'b0;
    #1;
    chk("ar_gnt", {29'd0, gnt}, 32'd0);
    chk("ar_bus", {28'd0, bus}, 32'd0);
    chk("ar_valid", {31'd0, bus_valid}, 32'd0);
    chk("ar_owner", {29'd0, owner}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    req = 3'b110;
    step();
    chk("ar_regnt", {29'd0, gnt}, 32'b010);

    // Release on the pre-emption edge is a plain release
    do_reset();
    req = 3'b010;
    step();
    req = 3'b110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rp_hold", {29'd0, gnt}, 32'b010);
    end
    req = 3'b100;
    step();
    chk("rp_gnt", {29'd0, gnt}, 32'b100);
    chk("rp_pre", {31'd0, preempt}, 32'd0);
    chk("rp_owner", {29'd0, owner}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1);
  end
endmodule
